key_press_decoder: RTL and testbench

Front-end input conditioner for the ColourMemory2000 top level. It synchronises and debounces the four active-low push-buttons `n_key`. Each completed single-key press is classified as short or long and handed to the game FSM through a one-entry valid/ready buffer. Short presses advance modes; long presses enter colour-sequence entries.

---
 rtl/key_press_decoder_pkg.sv | 29 ++
 rtl/key_debouncer.sv | 54 +++++
 rtl/key_press_decoder.sv | 127 ++++++++++++
 tb/tb_key_press_decoder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/key_press_decoder_pkg.sv
// Shared types and helpers for the key press decoder: FSM encoding,
// key index width and one-hot utilities used on the debounced key vector.
package key_press_decoder_pkg;

    localparam int KEY_IDX_W = 2;
    localparam int NUM_KEYS  = 4;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESSED      = 2'd1,
        WAIT_RELEASE = 2'd2
    } press_state_t;

    // True when exactly one key bit is set.
    function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    // Index of the lowest set bit; only meaningful for a one-hot vector.
    function automatic logic [KEY_IDX_W-1:0] key_index(input logic [NUM_KEYS-1:0] v);
        logic [KEY_IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) idx = KEY_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser and vector-wide debounce for the active-low keys.
// The synchronised vector must hold unchanged for DEBOUNCE_CYCLES before
// it is copied to the stable (active-high) output.
module key_debouncer
    import key_press_decoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                clock,
    input  logic                n_reset,
    input  logic [NUM_KEYS-1:0] n_key,
    output logic [NUM_KEYS-1:0] stable
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;
    logic [NUM_KEYS-1:0] r_cand;
    logic [NUM_KEYS-1:0] r_stable;
    logic [CNT_W-1:0]    r_db_cnt;

    // Invert and synchronise the raw keys; reset value 0 means "released".
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= ~n_key;
            r_sync2 <= r_sync1;
        end
    end

    // Restart the count on any change; accept the candidate once it has held long enough.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_cand   <= '0;
            r_db_cnt <= '0;
            r_stable <= '0;
        end else if (r_sync2 != r_cand) begin
            r_cand   <= r_sync2;
            r_db_cnt <= '0;
        end else if (r_db_cnt == CNT_LAST) begin
            r_stable <= r_cand;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign stable = r_stable;

endmodule

// File: rtl/key_press_decoder.sv
// Classifies each completed single-key press as short or long and hands it
// to the consumer through a one-entry valid/ready buffer. Chords are ignored
// until every key is released.
module key_press_decoder
    import key_press_decoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 12500000
) (
    input  logic                 clock,
    input  logic                 n_reset,
    input  logic [NUM_KEYS-1:0]  n_key,
    input  logic                 pressReady,
    output logic                 pressValid,
    output logic [KEY_IDX_W-1:0] pressKey,
    output logic                 pressLong,
    output logic                 overrun,
    output logic [NUM_KEYS-1:0]  keyHeld
);

    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

    logic [NUM_KEYS-1:0]  w_stable;
    logic [NUM_KEYS-1:0]  w_latched_onehot;
    press_state_t         r_state;
    press_state_t         w_next_state;
    logic [KEY_IDX_W-1:0] r_key_idx;
    logic [HOLD_W-1:0]    r_hold_cnt;
    logic                 w_event;
    logic                 w_event_long;
    logic                 w_accept;
    logic                 r_valid;
    logic [KEY_IDX_W-1:0] r_out_key;
    logic                 r_out_long;
    logic                 r_overrun;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock  (clock),
        .n_reset(n_reset),
        .n_key  (n_key),
        .stable (w_stable)
    );

    assign w_latched_onehot = NUM_KEYS'(1) << r_key_idx;
    assign w_accept         = r_valid && pressReady;

    // Press FSM state register.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    // Next state and event generation from the debounced key vector.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_event      = 1'b0;
        w_event_long = 1'b0;
        case (r_state)
            IDLE: begin
                if (is_onehot(w_stable))   w_next_state = PRESSED;
                else if (w_stable != '0)   w_next_state = WAIT_RELEASE;
            end
            PRESSED: begin
                if (w_stable == '0) begin
                    w_event      = 1'b1;
                    w_event_long = (r_hold_cnt >= HOLD_MAX);
                    w_next_state = IDLE;
                end else if (w_stable != w_latched_onehot) begin
                    w_next_state = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (w_stable == '0) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Latch the pressed key and count the hold, saturating at the long threshold.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_key_idx  <= '0;
            r_hold_cnt <= '0;
        end else if (r_state == IDLE && is_onehot(w_stable)) begin
            r_key_idx  <= key_index(w_stable);
            r_hold_cnt <= '0;
        end else if (r_state == PRESSED && r_hold_cnt != HOLD_MAX) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    // One-entry event buffer: accept frees it, a new event refills it, a full one drops and flags.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_valid    <= 1'b0;
            r_out_key  <= '0;
            r_out_long <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (w_accept) begin
            r_overrun <= 1'b0;
            r_valid   <= w_event;
            if (w_event) begin
                r_out_key  <= r_key_idx;
                r_out_long <= w_event_long;
            end
        end else if (w_event) begin
            if (r_valid) begin
                r_overrun <= 1'b1;
            end else begin
                r_valid    <= 1'b1;
                r_out_key  <= r_key_idx;
                r_out_long <= w_event_long;
            end
        end
    end

    assign pressValid = r_valid;
    assign pressKey   = r_out_key;
    assign pressLong  = r_out_long;
    assign overrun    = r_overrun;
    assign keyHeld    = w_stable;

endmodule

// File: tb/tb_key_press_decoder.sv
// Directed bench for key_press_decoder at 5000 Hz with short debounce and
// long-press thresholds.
`timescale 1us/1ns
module tb_key_press_decoder;

    logic       clock = 1'b0;
    logic       n_reset = 1'b0;
    logic [3:0] n_key = 4'hF;
    logic       pressReady = 1'b0;
    logic       pressValid;
    logic [1:0] pressKey;
    logic       pressLong;
    logic       overrun;
    logic [3:0] keyHeld;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state, written only by the monitor process.
    int         ev_cnt   = 0;
    int         held_cnt = 0;
    logic [1:0] last_key = 2'd0;
    logic       last_long = 1'b0;

    key_press_decoder #(
        .DEBOUNCE_CYCLES(50),
        .LONG_CYCLES    (1250)
    ) dut (
        .clock     (clock),
        .n_reset   (n_reset),
        .n_key     (n_key),
        .pressReady(pressReady),
        .pressValid(pressValid),
        .pressKey  (pressKey),
        .pressLong (pressLong),
        .overrun   (overrun),
        .keyHeld   (keyHeld)
    );

    always #100 clock = ~clock;

    // Count accepted events and cycles with any debounced key held.
    always @(negedge clock) begin
        if (pressValid && pressReady) begin
            ev_cnt    <= ev_cnt + 1;
            last_key  <= pressKey;
            last_long <= pressLong;
        end
        if (keyHeld != 4'h0) held_cnt <= held_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        int base_ev;
        int base_held;
        int lat;

        // Reset held low while keys toggle: every output stays zero.
        cycles(2);
        for (int i = 0; i < 5; i++) begin
            n_key = (i % 2 == 0) ? 4'b1110 : 4'hF;
            cycles(20);
            check("reset_outputs_zero", {23'd0, pressValid, pressKey, pressLong, overrun, keyHeld}, 32'd0);
        end
        n_key = 4'hF;
        cycles(1);
        n_reset = 1'b1;
        cycles(100);
        check("post_reset_outputs_zero", {23'd0, pressValid, pressKey, pressLong, overrun, keyHeld}, 32'd0);

        // Long press of key 0 with the consumer always ready.
        pressReady = 1'b1;
        base_ev = ev_cnt;
        n_key = 4'b1110;
        cycles(200);
        check("long_keyheld", {28'd0, keyHeld}, 32'h1);
        check("long_no_event_while_held", {31'd0, pressValid}, 32'd0);
        cycles(4800);
        n_key = 4'hF;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            cycles(1);
            if (pressValid) begin
                lat = i;
                break;
            end
        end
        check("long_latency_51_to_55", {31'd0, (lat >= 51 && lat <= 55)}, 32'd1);
        check("long_key", {30'd0, pressKey}, 32'd0);
        check("long_flag", {31'd0, pressLong}, 32'd1);
        cycles(1);
        check("long_valid_one_cycle", {31'd0, pressValid}, 32'd0);
        cycles(100);
        check("long_event_count", ev_cnt - base_ev, 32'd1);

        // Short press of key 3.
        base_ev = ev_cnt;
        n_key = 4'b0111;
        cycles(250);
        n_key = 4'hF;
        cycles(150);
        check("short_event_count", ev_cnt - base_ev, 32'd1);
        check("short_key", {30'd0, last_key}, 32'd3);
        check("short_flag", {31'd0, last_long}, 32'd0);

        // Key 2 bouncing every 10 cycles never settles.
        base_ev   = ev_cnt;
        base_held = held_cnt;
        for (int i = 0; i < 20; i++) begin
            n_key = (i % 2 == 0) ? 4'b1011 : 4'hF;
            cycles(10);
        end
        n_key = 4'hF;
        cycles(150);
        check("bounce_keyheld_never_set", held_cnt - base_held, 32'd0);
        check("bounce_no_event", ev_cnt - base_ev, 32'd0);

        // Chord: key 1 then key 1+2, released together; no event.
        base_ev = ev_cnt;
        n_key = 4'b1101;
        cycles(500);
        check("chord_keyheld_single", {28'd0, keyHeld}, 32'h2);
        n_key = 4'b1001;
        cycles(500);
        check("chord_keyheld_double", {28'd0, keyHeld}, 32'h6);
        n_key = 4'hF;
        cycles(200);
        check("chord_no_event", ev_cnt - base_ev, 32'd0);
        check("chord_released", {28'd0, keyHeld}, 32'h0);

        // A clean key 0 press after the chord decodes normally.
        base_ev = ev_cnt;
        n_key = 4'b1110;
        cycles(250);
        n_key = 4'hF;
        cycles(150);
        check("after_chord_event_count", ev_cnt - base_ev, 32'd1);
        check("after_chord_key", {30'd0, last_key}, 32'd0);
        check("after_chord_flag", {31'd0, last_long}, 32'd0);

        // Backpressure: first event is held, second is dropped and flagged.
        pressReady = 1'b0;
        n_key = 4'b1101;
        cycles(250);
        n_key = 4'hF;
        cycles(150);
        check("bp_first_valid", {31'd0, pressValid}, 32'd1);
        check("bp_first_key", {30'd0, pressKey}, 32'd1);
        check("bp_no_overrun_yet", {31'd0, overrun}, 32'd0);
        n_key = 4'b1011;
        cycles(1500);
        n_key = 4'hF;
        cycles(150);
        check("bp_still_valid", {31'd0, pressValid}, 32'd1);
        check("bp_key_kept", {30'd0, pressKey}, 32'd1);
        check("bp_long_kept", {31'd0, pressLong}, 32'd0);
        check("bp_overrun_set", {31'd0, overrun}, 32'd1);
        pressReady = 1'b1;
        cycles(1);
        pressReady = 1'b0;
        check("bp_accept_valid_clear", {31'd0, pressValid}, 32'd0);
        check("bp_accept_overrun_clear", {31'd0, overrun}, 32'd0);
        cycles(20);
        check("bp_stays_empty", {31'd0, pressValid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
